// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  localparam int REG_AW = 3;
  localparam int CNT_W  = 16;
  localparam int CYC_W  = 3;

  localparam logic [15:0] NOP_INSTR = 16'hC000;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LD_STALL = 2'd1,
    FLUSH    = 2'd2,
    MEM_WAIT = 2'd3
  } hz_state_e;

  typedef struct packed {
    logic dhz;
    logic chz;
    logic pc_write;
    logic bubble;
  } hz_ctrl_t;

  // A load whose destination feeds the very next instruction; r0 never hazards.
  function automatic logic load_use_hit(
    input logic              memread,
    input logic [REG_AW-1:0] ld_rt,
    input logic [REG_AW-1:0] rs,
    input logic [REG_AW-1:0] rt
  );
    return memread && (ld_rt != '0) && ((ld_rt == rs) || (ld_rt == rt));
  endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter; cleared only by reset, holds at all-ones.
module sat_counter
  import hazard_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_o <= '0;
    end else if (inc_i && (cnt_o != {W{1'b1}})) begin
      cnt_o <= cnt_o + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes and memory freezes,
// with saturating statistics counters for stall and flush cycles.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES      = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [REG_AW-1:0] ifid_rs_i,
  input  logic [REG_AW-1:0] ifid_rt_i,
  input  logic              idex_memread_i,
  input  logic [REG_AW-1:0] idex_rt_i,
  input  logic              branch_taken_i,
  input  logic              mem_busy_i,
  output logic              DHZ_o,
  output logic              CHZ_o,
  output logic              pc_write_o,
  output logic              idex_bubble_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  // The first hazard cycle is spent in RUN, so the countdown covers the rest.
  localparam logic [CYC_W-1:0] LD_RELOAD = CYC_W'(LOAD_STALL_CYCLES - 1);
  localparam logic [CYC_W-1:0] FL_RELOAD = CYC_W'(FLUSH_CYCLES - 1);
  localparam bit               LD_MULTI  = (LOAD_STALL_CYCLES > 1);
  localparam bit               FL_MULTI  = (FLUSH_CYCLES > 1);

  hz_state_e        state_q, state_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic             hit;
  hz_ctrl_t         ctrl;

  assign hit = load_use_hit(idex_memread_i, idex_rt_i, ifid_rs_i, ifid_rt_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= RUN;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    unique case (state_q)
      RUN, MEM_WAIT: begin
        if (mem_busy_i) begin
          state_d = MEM_WAIT;
          cyc_d   = '0;
        end else if (state_q == MEM_WAIT) begin
          state_d = RUN;
          cyc_d   = '0;
        end else if (branch_taken_i) begin
          state_d = FL_MULTI ? FLUSH : RUN;
          cyc_d   = FL_MULTI ? FL_RELOAD : '0;
        end else if (hit) begin
          state_d = LD_MULTI ? LD_STALL : RUN;
          cyc_d   = LD_MULTI ? LD_RELOAD : '0;
        end else begin
          state_d = RUN;
          cyc_d   = '0;
        end
      end
      FLUSH: begin
        if (mem_busy_i) begin
          state_d = MEM_WAIT;
          cyc_d   = '0;
        end else if (cyc_q <= CYC_W'(1)) begin
          state_d = RUN;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q - 1'b1;
        end
      end
      LD_STALL: begin
        if (mem_busy_i) begin
          state_d = MEM_WAIT;
          cyc_d   = '0;
        end else if (branch_taken_i) begin
          state_d = FL_MULTI ? FLUSH : RUN;
          cyc_d   = FL_MULTI ? FL_RELOAD : '0;
        end else if (cyc_q <= CYC_W'(1)) begin
          state_d = RUN;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q - 1'b1;
        end
      end
      default: begin
        state_d = RUN;
        cyc_d   = '0;
      end
    endcase
  end

  // Mealy outputs; forced quiet while reset is held so the pipeline sees no stray enables.
  always_comb begin
    ctrl = '0;
    if (!rst_i) begin
      unique case (state_q)
        RUN, MEM_WAIT: begin
          if (mem_busy_i) begin
            ctrl.dhz = 1'b1;
          end else if (branch_taken_i) begin
            ctrl.chz      = 1'b1;
            ctrl.pc_write = 1'b1;
          end else if (hit) begin
            ctrl.dhz    = 1'b1;
            ctrl.bubble = 1'b1;
          end else begin
            ctrl.pc_write = 1'b1;
          end
        end
        FLUSH: begin
          if (mem_busy_i) begin
            ctrl.dhz = 1'b1;
          end else begin
            ctrl.chz      = 1'b1;
            ctrl.pc_write = 1'b1;
          end
        end
        LD_STALL: begin
          if (mem_busy_i) begin
            ctrl.dhz = 1'b1;
          end else if (branch_taken_i) begin
            ctrl.chz      = 1'b1;
            ctrl.pc_write = 1'b1;
          end else begin
            ctrl.dhz    = 1'b1;
            ctrl.bubble = 1'b1;
          end
        end
        default: ctrl = '0;
      endcase
    end
  end

  assign DHZ_o         = ctrl.dhz;
  assign CHZ_o         = ctrl.chz;
  assign pc_write_o    = ctrl.pc_write;
  assign idex_bubble_o = ctrl.bubble;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (DHZ_o),
    .cnt_o (stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (CHZ_o),
    .cnt_o (flush_cnt_o)
  );

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter LOAD_STALL_CYCLES, default 1, number of stall cycles per load-use hazard (range 1..7).
REQ-002 SHALL have parameter FLUSH_CYCLES, default 1, number of IF/ID flush cycles per taken branch (range 1..7).
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on posedge.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port ifid_rs_i  input  3  source register rs of instruction in IF/ID.
REQ-006 SHALL have port ifid_rt_i  input  3  source register rt of instruction in IF/ID.
REQ-007 SHALL have port idex_memread_i  input  1  instruction in ID/EX is a load.
REQ-008 SHALL have port idex_rt_i  input  3  load destination register in ID/EX.
REQ-009 SHALL have port branch_taken_i  input  1  branch resolved taken this cycle.
REQ-010 SHALL have port mem_busy_i  input  1  data memory not ready; front end must freeze.
REQ-011 SHALL have port DHZ_o  output  1  IF/ID hold (data hazard stall).
REQ-012 SHALL have port CHZ_o  output  1  IF/ID flush; IF/ID loads nop 16'hC000.
REQ-013 SHALL have port pc_write_o  output  1  PC register update enable.
REQ-014 SHALL have port idex_bubble_o  output  1  zero ID/EX control fields.
REQ-015 SHALL have port stall_cnt_o  output  16  saturating count of cycles with DHZ_o=1.
REQ-016 SHALL have port flush_cnt_o  output  16  saturating count of cycles with CHZ_o=1.

Function
REQ-017 SHALL implement FSM states RUN, LD_STALL, FLUSH, MEM_WAIT plus 3-bit cycle counter cyc.
REQ-018 Load-use hit SHALL be idex_memread_i=1 AND idex_rt_i!=0 AND (idex_rt_i==ifid_rs_i OR idex_rt_i==ifid_rt_i).
REQ-019 In RUN, priority SHALL be mem_busy_i > branch_taken_i > load-use hit; outputs respond in the same cycle (Mealy).
REQ-020 RUN + mem_busy_i: DHZ_o=1, pc_write_o=0, idex_bubble_o=0, CHZ_o=0; next state MEM_WAIT.
REQ-021 MEM_WAIT: same outputs as REQ-020 while mem_busy_i=1; on mem_busy_i=0, outputs revert to RUN evaluation that cycle and next state is RUN.
REQ-022 RUN + branch_taken_i: CHZ_o=1, pc_write_o=1, DHZ_o=0; if FLUSH_CYCLES>1 next state FLUSH with cyc=FLUSH_CYCLES-1, else stay RUN.
REQ-023 FLUSH: CHZ_o=1, pc_write_o=1; cyc decrements each cycle; exit to RUN when cyc reaches 1 on that cycle's edge; mem_busy_i in FLUSH preempts to MEM_WAIT, abandoning the remaining flush cycles.
REQ-024 RUN + load-use hit: DHZ_o=1, pc_write_o=0, idex_bubble_o=1; if LOAD_STALL_CYCLES>1 next state LD_STALL with cyc=LOAD_STALL_CYCLES-1, else stay RUN.
REQ-025 LD_STALL: DHZ_o=1, pc_write_o=0, idex_bubble_o=1, decrementing cyc as in FLUSH; branch_taken_i in LD_STALL SHALL abort the stall and behave as REQ-022.
REQ-026 DHZ_o and CHZ_o SHALL never both be 1; in RUN with no event all control outputs SHALL be 0 except pc_write_o=1.
REQ-027 Counters SHALL increment by 1 per qualifying cycle and hold at 16'hFFFF (no wrap).

Reset
REQ-028 While rst_i=1: state=RUN, cyc=0, counters=0, DHZ_o=0, CHZ_o=0, pc_write_o=0, idex_bubble_o=0.
REQ-029 Reset asserted mid-stall/flush/mem-wait SHALL abort immediately; first post-reset cycle evaluates as RUN.

Structure
REQ-030 Package hazard_pkg SHALL hold the state enum, NOP_INSTR=16'hC000, REG_AW=3, CNT_W=16.
REQ-031 Both counters SHALL be instances of one sub-module sat_counter (inc, clr via reset, 16-bit saturating).

Verification
REQ-032 idex_memread_i=1, idex_rt_i=3, ifid_rs_i=3, LOAD_STALL_CYCLES=2 -> DHZ_o=1, pc_write_o=0, idex_bubble_o=1 for exactly 2 cycles; stall_cnt_o=2.
REQ-033 idex_rt_i=0, ifid_rs_i=0, idex_memread_i=1 -> no stall; pc_write_o=1.
REQ-034 branch_taken_i=1 one cycle, FLUSH_CYCLES=1 -> CHZ_o=1 for one cycle; flush_cnt_o=1.
REQ-035 branch_taken_i and load-use hit same cycle -> CHZ_o=1, DHZ_o=0; mem_busy_i also high -> DHZ_o=1, CHZ_o=0.
REQ-036 mem_busy_i high 5 cycles, rst_i pulsed in cycle 3 -> outputs 0 during reset, counters 0, FSM returns RUN.
REQ-037 Force 65540 stall cycles -> stall_cnt_o=16'hFFFF, no wrap.
